// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled sck/cs/mosi, one-entry TX buffer,
// received-word strobe and partial-frame error pulse.
module spi_target #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sck,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              frame_err
);

    typedef enum logic [1:0] {
        RESYNC,
        IDLE,
        SHIFT
    } state_t;

    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    logic [1:0] sck_q;
    logic [1:0] cs_q;
    logic [1:0] mosi_q;
    logic       sck_d;
    logic       cs_d;
    logic       sck_s;
    logic       cs_s;
    logic       mosi_s;
    logic       sck_rise;
    logic       sck_fall;
    logic       cs_rise;
    logic       cs_fall;

    state_t            state;
    state_t            state_n;
    logic              start;
    logic              shift_in;
    logic              shift_out;
    logic              abort;
    logic              tx_load;
    logic              tx_shift;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] rx_next;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] buf_data;
    logic              buf_full;

    // Synchronisers keep sampling through reset so the first cycle after
    // reset already sees the true pin levels (no false cs edge).
    always_ff @(posedge clk) begin
        sck_q  <= {sck_q[0], sck};
        cs_q   <= {cs_q[0], cs};
        mosi_q <= {mosi_q[0], mosi};
        sck_d  <= sck_q[1];
        cs_d   <= cs_q[1];
    end

    assign sck_s    = sck_q[1];
    assign cs_s     = cs_q[1];
    assign mosi_s   = mosi_q[1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign cs_rise  = cs_s & ~cs_d;
    assign cs_fall  = ~cs_s & cs_d;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= RESYNC;
        else        state <= state_n;
    end

    // Next state and per-cycle actions; cs_fall masks any sck edge.
    always_comb begin
        state_n   = state;
        start     = 1'b0;
        shift_in  = 1'b0;
        shift_out = 1'b0;
        abort     = 1'b0;
        unique case (state)
            RESYNC: begin
                if (!cs_s) state_n = IDLE;
            end
            IDLE: begin
                if (cs_rise) begin
                    state_n = SHIFT;
                    start   = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_fall) begin
                    state_n = IDLE;
                    abort   = 1'b1;
                end else begin
                    shift_in  = sck_rise;
                    shift_out = sck_fall;
                end
            end
            default: state_n = RESYNC;
        endcase
    end

    assign rx_next  = {rx_sr[DATA_W-2:0], mosi_s};
    assign tx_load  = start | (shift_out & (cnt == '0));
    assign tx_shift = shift_out & (cnt != '0);

    // Bit counter, shift registers, TX buffer and output strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            buf_data  <= '0;
            buf_full  <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (start) cnt <= '0;
            if (shift_in) begin
                rx_sr <= rx_next;
                if (cnt == LAST) begin
                    cnt      <= '0;
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (abort) begin
                frame_err <= (cnt != '0);
                cnt       <= '0;
            end
            if (tx_load)       tx_sr <= buf_full ? buf_data : '0;
            else if (tx_shift) tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            // A word arriving on a load cycle waits for the next boundary.
            if (tx_load && buf_full) begin
                buf_full <= 1'b0;
            end else if (tx_valid && !buf_full) begin
                buf_full <= 1'b1;
                buf_data <= tx_data;
            end
        end
    end

    assign miso     = (state == SHIFT) & tx_sr[DATA_W-1];
    assign busy     = (state == SHIFT);
    assign tx_ready = ~buf_full;

endmodule

// File: tb/tb_spi_target.sv
// Randomised scoreboard bench for spi_target: a bench-side master drives
// frames, a monitor checks every rx_valid against queued expectations.
module tb_spi_target;

    localparam int W    = 8;
    localparam int HALF = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sck = 1'b0;
    logic         cs = 1'b1;
    logic         mosi = 1'b0;
    logic         miso;
    logic [W-1:0] tx_data = '0;
    logic         tx_valid = 1'b0;
    logic         tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         busy;
    logic         frame_err;

    int total = 0;
    int bad = 0;
    int err_seen = 0;
    int err_exp = 0;
    logic [W-1:0] txq[$];
    logic [W-1:0] rxq[$];
    logic [W-1:0] last_rx = '0;

    spi_target #(.DATA_W(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sck(sck),
        .cs(cs),
        .mosi(mosi),
        .miso(miso),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .busy(busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    // Model of the one-entry buffer: each load point takes the held word or zero.
    function automatic logic [W-1:0] pop_tx();
        if (txq.size() > 0) return txq.pop_front();
        return '0;
    endfunction

    // Monitor: every rx_valid must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && rx_valid) begin
            if (rxq.size() == 0) chk("rx_unexpected", rx_valid, 0);
            else chk("rx_data", rx_data, rxq.pop_front());
        end
        if (rst_n && frame_err) err_seen++;
    end

    task automatic load(input logic [W-1:0] v);
        @(negedge clk);
        chk("load_ready", tx_ready, 1);
        tx_data  = v;
        tx_valid = 1'b1;
        txq.push_back(v);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("load_taken", tx_ready, 0);
    endtask

    task automatic do_bit(input logic m, input bit want, input logic [W-1:0] rv,
                          output logic got);
        bit done;
        done = 0;
        mosi = m;
        repeat (HALF) @(negedge clk);
        got = miso;
        sck = 1'b1;
        for (int c = 0; c < HALF; c++) begin
            @(negedge clk);
            if (want && !done && rx_valid) begin
                chk("refill_ready", tx_ready, 1);
                tx_data  = rv;
                tx_valid = 1'b1;
                txq.push_back(rv);
                done = 1;
            end else begin
                tx_valid = 1'b0;
            end
        end
        tx_valid = 1'b0;
        if (want) chk("refill_window", done, 1);
        sck = 1'b0;
    endtask

    task automatic frame(input int nw, input logic [W-1:0] rw[3],
                         input bit rf[3], input logic [W-1:0] rv[3]);
        logic [W-1:0] exp_w;
        logic [W-1:0] got_w;
        logic g;
        cs = 1'b1;
        exp_w = pop_tx();
        repeat (HALF) @(negedge clk);
        chk("ready_at_start", tx_ready, 1);
        chk("busy_in_frame", busy, 1);
        for (int w = 0; w < nw; w++) begin
            rxq.push_back(rw[w]);
            for (int b = W - 1; b >= 0; b--) begin
                do_bit(rw[w][b], rf[w] && (b == 0), rv[w], g);
                got_w[b] = g;
            end
            chk("miso_word", got_w, exp_w);
            last_rx = rw[w];
            exp_w = pop_tx();
        end
        repeat (HALF) @(negedge clk);
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic partial(input int nb, input logic [W-1:0] v);
        logic g;
        cs = 1'b1;
        void'(pop_tx());
        repeat (HALF) @(negedge clk);
        for (int b = 0; b < nb; b++) do_bit(v[W-1-b], 0, '0, g);
        repeat (HALF) @(negedge clk);
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rw[3];
        logic [W-1:0] rv[3];
        bit rf[3];
        logic g;
        int nw;

        rf = '{0, 0, 0};
        rv = '{0, 0, 0};
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_miso", miso, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_tx_ready", tx_ready, 1);
        for (int i = 0; i < 4; i++) begin
            sck = ~sck;
            repeat (HALF) @(negedge clk);
            chk("resync_busy", busy, 0);
        end
        sck = 1'b0;
        cs = 1'b0;
        repeat (HALF) @(negedge clk);

        load(8'hA5);
        rw = '{8'h3C, 0, 0};
        frame(1, rw, rf, rv);

        load(8'h81);
        rw = '{8'h11, 8'h22, 0};
        rf = '{1, 0, 0};
        rv = '{8'h7E, 0, 0};
        frame(2, rw, rf, rv);
        rf = '{0, 0, 0};

        rw = '{8'hF0, 0, 0};
        frame(1, rw, rf, rv);

        err_exp++;
        partial(5, 8'h99);
        chk("abort_err", err_seen, err_exp);
        chk("abort_rx_hold", rx_data, last_rx);
        rw = '{8'h5A, 0, 0};
        frame(1, rw, rf, rv);

        load(8'hC3);
        cs = 1'b1;
        void'(pop_tx());
        repeat (HALF) @(negedge clk);
        for (int b = 0; b < 3; b++) do_bit(1'b1, 0, '0, g);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        txq.delete();
        last_rx = '0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", tx_ready, 1);
        chk("mid_rst_rx_data", rx_data, 0);
        chk("mid_rst_miso", miso, 0);
        for (int b = 0; b < 5; b++) do_bit(1'b1, 0, '0, g);
        repeat (HALF) @(negedge clk);
        chk("mid_rst_no_busy", busy, 0);
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
        rw = '{8'h6B, 0, 0};
        frame(1, rw, rf, rv);

        for (int f = 0; f < 16; f++) begin
            nw = int'($urandom_range(1, 3));
            for (int k = 0; k < 3; k++) begin
                rw[k] = W'($urandom);
                rv[k] = W'($urandom);
                rf[k] = bit'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 1) == 1 && txq.size() == 0) load(W'($urandom));
            frame(nw, rw, rf, rv);
        end

        repeat (4 * HALF) @(negedge clk);
        chk("frame_err_count", err_seen, err_exp);
        chk("rx_pending", rxq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
